cavlc_block_seq: RTL and testbench
==================================

Name: cavlc_block_seq

Overview:
- Per-4x4-block sequencer for the CAVLC entropy encoder.
- Launches the five syntax-element encoders in order (coeff_token, trailing-ones signs, levels, total_zeros, run_before) using each encoder's start/finish handshake.
- Skips stages the standard omits for the block and merges the per-stage bit streams into one serial FIFO write port.
- Sits between the block-statistics front end and the bitstream FIFO.

Parameters:
MAX_COEFF, 16, coefficients per block (15 for AC/Intra16x16 blocks); controls the total_zeros skip rule.
WDOG_CYCLES, 64, maximum cycles one stage may hold start without finish before a timeout.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
blk_valid  in  1  block statistics valid
blk_ready  out  1  sequencer idle, statistics accepted this cycle if blk_valid
total_coeff  in  5  TotalCoeff (0..16)
t1  in  2  TrailingOnes (0..3)
total_zeros  in  4  TotalZeros
start_o  out  5  one-hot stage start: [0]=ct [1]=t1s [2]=lvl [3]=tz [4]=rb
finish_i  in  5  stage finish flags, same bit order
push_i  in  5  stage fifo_push, same bit order
data_i  in  5  stage fifo_data, same bit order
fifo_afull  in  1  bitstream FIFO almost full
fifo_push  out  1  merged push
fifo_data  out  1  merged data bit
blk_done  out  1  one-cycle pulse at end of block
err_timeout  out  1  sticky stage timeout flag

Behaviour:
- Reset values: every output is 0, except blk_ready=1 (IDLE). State is IDLE.
- States: IDLE, WAIT_ROOM, RUN, GAP, DONE.
- IDLE:
  - blk_ready=1.
  - On blk_valid, register total_coeff, t1 and total_zeros, clear err_timeout, set stage=CT, go to WAIT_ROOM.
- WAIT_ROOM:
  - All start_o bits are 0.
  - Go to RUN on the first cycle fifo_afull=0.
- RUN:
  - start_o[stage]=1 and is held until finish_i[stage]=1. On that cycle go to GAP.
  - The watchdog counts RUN cycles. When the count reaches WDOG_CYCLES: set err_timeout, drop start, go to DONE.
- GAP:
  - Exactly one cycle with start_o=0, so the encoder clears its finish flag and counters.
  - Then select the next stage and go to WAIT_ROOM, or to DONE if no stage remains.
- Next-stage rules, evaluated in order from the stage after the current one:
  - t1s runs only if t1!=0.
  - lvl runs only if total_coeff>t1.
  - tz runs only if 0<total_coeff<MAX_COEFF.
  - rb runs only if total_coeff>1 and total_zeros!=0.
  - total_coeff=0 gives CT only.
- DONE: blk_done=1 for one cycle, then IDLE. blk_valid is ignored outside IDLE.
- Merge:
  - fifo_push=push_i[stage] and fifo_data=data_i[stage], where stage is the registered current stage, held through GAP.
  - Both outputs are combinational from the registered stage select.
  - push_i/data_i of non-selected stages are ignored.
  - In IDLE, fifo_push=0.
- Stage timing: latency from blk_valid accept to the first start is 2 cycles when fifo_afull=0. Each stage costs its encoder time plus 2 cycles (GAP + WAIT_ROOM).
- finish_i and push_i asserted in the same cycle: the push is still forwarded.
- fifo_afull is sampled only in WAIT_ROOM. A stage already running is never paused.
- Reset mid-block: returns to IDLE immediately and all starts drop asynchronously.

Optional Feature:
CAVLC_BIT_COUNT_EN
- Defined:
  - Adds output blk_bits[8:0], which counts merged fifo_push cycles for the current block.
  - The count clears on block accept and is valid/stable from blk_done until the next accept.
- Undefined: no counter and no port. All other behaviour is identical.

Decomposition:
- Package cavlc_pkg: stage index constants (ST_CT=0..ST_RB=4), FSM state encoding, MAX_COEFF default, width constants.
- Sub-module cavlc_stage_mux: combinational 5:1 push/data selector driven by stage.
- The skip logic stays in the top level as a function.

Test Plan:
1. total_coeff=0 -> only start_o[0] pulses; blk_done 2 cycles after finish_i[0]; no other start.
2. total_coeff=5, t1=2, total_zeros=3 -> starts in order 0,1,2,3,4, each separated by one all-zero GAP cycle; fifo_data equals the concatenated stage streams.
3. total_coeff=16, t1=3, total_zeros=0 -> stages 0,1,2 only; tz and rb skipped.
4. fifo_afull=1 held for 10 cycles during WAIT_ROOM before lvl -> start_o[2] rises the cycle after fifo_afull falls.
5. finish_i[3] never asserted -> err_timeout=1 after 64 RUN cycles; blk_done pulses; blk_ready=1 next cycle.
6. rst low mid-RUN of stage 2 -> all outputs 0 and blk_ready=1 within the same cycle; the next block proceeds normally.

Source files
------------

// File: rtl/cavlc_pkg.sv
// cavlc_pkg: shared stage indices, FSM encoding and defaults for the CAVLC block sequencer.
package cavlc_pkg;
   localparam int NST = 5;
   localparam int SW = 3;
   localparam logic [SW-1:0] ST_CT = 3'd0;
   localparam logic [SW-1:0] ST_T1S = 3'd1;
   localparam logic [SW-1:0] ST_LVL = 3'd2;
   localparam logic [SW-1:0] ST_TZ = 3'd3;
   localparam logic [SW-1:0] ST_RB = 3'd4;
   localparam int MAX_COEFF_DEF = 16;
   localparam int WDOG_DEF = 64;
   typedef enum logic [2:0] {S_IDLE, S_WAIT_ROOM, S_RUN, S_GAP, S_DONE} state_t;
endpackage

// File: rtl/cavlc_stage_mux.sv
// cavlc_stage_mux: selects one stage encoder's push/data onto the shared bitstream port.
module cavlc_stage_mux
   import cavlc_pkg::*;
(
   input  logic [SW-1:0]  stage_i,
   input  logic           en_i,
   input  logic [NST-1:0] push_i,
   input  logic [NST-1:0] data_i,
   output logic           push_o,
   output logic           data_o
);
   always_comb begin
      push_o = en_i ? push_i[stage_i] : 1'b0;
      data_o = en_i ? data_i[stage_i] : 1'b0;
   end
endmodule

// File: rtl/cavlc_block_seq.sv
// cavlc_block_seq: runs the five CAVLC syntax-element encoders per 4x4 block and merges their bits.
// Define CAVLC_BIT_COUNT_EN to add the blk_bits per-block push counter.
module cavlc_block_seq
   import cavlc_pkg::*;
#(
   parameter int MAX_COEFF = MAX_COEFF_DEF,
   parameter int WDOG_CYCLES = WDOG_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       blk_valid,
   output logic       blk_ready,
   input  logic [4:0] total_coeff,
   input  logic [1:0] t1,
   input  logic [3:0] total_zeros,
   output logic [4:0] start_o,
   input  logic [4:0] finish_i,
   input  logic [4:0] push_i,
   input  logic [4:0] data_i,
   input  logic       fifo_afull,
   output logic       fifo_push,
   output logic       fifo_data,
   output logic       blk_done,
   output logic       err_timeout
`ifdef CAVLC_BIT_COUNT_EN
   ,
   output logic [8:0] blk_bits
`endif
);
   localparam int WW = $clog2(WDOG_CYCLES) + 1;

   state_t          state_q;
   logic [SW-1:0]   stage_q;
   logic [4:0]      tc_q;
   logic [1:0]      t1_q;
   logic [3:0]      tz_q;
   logic [WW-1:0]   wdog_q;
   logic [NST-1:0]  start_q;
   logic            ready_q, done_q, err_q;
   logic [SW:0]     nxt_d;

   // Lowest-numbered stage after cur whose syntax element is present; MSB flags "found".
   function automatic logic [SW:0] next_stage(input logic [SW-1:0] cur, input logic [4:0] tc,
                                               input logic [1:0] t1v, input logic [3:0] tz);
      logic [NST-1:0] run;
      logic [SW:0]    res;
      run = '0;
      run[ST_CT] = 1'b1;
      run[ST_T1S] = tc != 5'd0 && t1v != 2'd0;
      run[ST_LVL] = tc > {3'd0, t1v};
      run[ST_TZ] = tc != 5'd0 && tc < 5'(MAX_COEFF);
      run[ST_RB] = tc > 5'd1 && tz != 4'd0;
      res = '0;
      for (int s = NST - 1; s >= 0; s--)
         if (SW'(s) > cur && run[s]) res = {1'b1, SW'(s)};
      return res;
   endfunction

   always_comb nxt_d = next_stage(stage_q, tc_q, t1_q, tz_q);

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= S_IDLE;
         stage_q <= ST_CT;
         tc_q <= '0;
         t1_q <= '0;
         tz_q <= '0;
         wdog_q <= '0;
         start_q <= '0;
         ready_q <= 1'b1;
         done_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: if (blk_valid) begin
               tc_q <= total_coeff;
               t1_q <= t1;
               tz_q <= total_zeros;
               err_q <= 1'b0;
               stage_q <= ST_CT;
               ready_q <= 1'b0;
               state_q <= S_WAIT_ROOM;
            end
            S_WAIT_ROOM: if (!fifo_afull) begin
               start_q <= NST'(1) << stage_q;
               wdog_q <= '0;
               state_q <= S_RUN;
            end
            S_RUN: if (finish_i[stage_q]) begin
               start_q <= '0;
               state_q <= S_GAP;
            end else if (wdog_q == WW'(WDOG_CYCLES - 1)) begin
               start_q <= '0;
               err_q <= 1'b1;
               done_q <= 1'b1;
               state_q <= S_DONE;
            end else wdog_q <= wdog_q + 1'b1;
            S_GAP: if (nxt_d[SW]) begin
               stage_q <= nxt_d[SW-1:0];
               state_q <= S_WAIT_ROOM;
            end else begin
               done_q <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end

   cavlc_stage_mux u_mux (
      .stage_i(stage_q),
      .en_i   (state_q != S_IDLE),
      .push_i (push_i),
      .data_i (data_i),
      .push_o (fifo_push),
      .data_o (fifo_data)
   );

   assign start_o = start_q;
   assign blk_ready = ready_q;
   assign blk_done = done_q;
   assign err_timeout = err_q;

`ifdef CAVLC_BIT_COUNT_EN
   logic [8:0] bits_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) bits_q <= '0;
      else if (state_q == S_IDLE && blk_valid) bits_q <= '0;
      else if (fifo_push) bits_q <= bits_q + 1'b1;
   assign blk_bits = bits_q;
`endif
endmodule

// File: tb/tb_cavlc_block_seq.sv
// tb_cavlc_block_seq: table-driven block vectors plus afull, timeout and reset sequences.
module tb_cavlc_block_seq;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic blk_valid = 1'b0;
   logic blk_ready;
   logic [4:0] total_coeff = '0;
   logic [1:0] t1 = '0;
   logic [3:0] total_zeros = '0;
   logic [4:0] start_o, finish_i, push_i, data_i;
   logic fifo_afull = 1'b0;
   logic fifo_push, fifo_data, blk_done, err_timeout;

   int checks = 0;
   int errors = 0;

   // Stub encoder s pushes s+2 bits, bit i = PAT[s][i], and finishes on its last push.
   localparam logic [7:0] PAT [5] = '{8'hA5, 8'h3C, 8'h96, 8'h5A, 8'hC3};
   logic [4:0] block_fin = '0;
   int enc_cnt;

   cavlc_block_seq dut (
      .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .total_coeff(total_coeff), .t1(t1), .total_zeros(total_zeros),
      .start_o(start_o), .finish_i(finish_i), .push_i(push_i), .data_i(data_i),
      .fifo_afull(fifo_afull), .fifo_push(fifo_push), .fifo_data(fifo_data),
      .blk_done(blk_done), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst)
      if (!rst) enc_cnt <= 0;
      else enc_cnt <= (|start_o && !(|finish_i)) ? enc_cnt + 1 : 0;

   always_comb begin
      finish_i = '0;
      push_i = start_o;
      data_i = '0;
      for (int s = 0; s < 5; s++) begin
         data_i[s] = PAT[s][enc_cnt[2:0]];
         if (start_o[s] && enc_cnt == s + 1 && !block_fin[s]) finish_i[s] = 1'b1;
      end
   end

   logic cap_clr = 1'b0;
   logic [31:0] got_bits;
   int got_len;
   logic [4:0] got_mask, last_st, prev_st;
   logic got_order_ok;

   always @(posedge clk)
      if (cap_clr) begin
         got_bits <= '0;
         got_len <= 0;
         got_mask <= '0;
         last_st <= '0;
         prev_st <= '0;
         got_order_ok <= 1'b1;
      end else begin
         if (fifo_push) begin
            got_bits <= {got_bits[30:0], fifo_data};
            got_len <= got_len + 1;
         end
         if (|start_o && prev_st == '0) begin
            got_mask <= got_mask | start_o;
            got_order_ok <= got_order_ok && (start_o > last_st);
            last_st <= start_o;
         end
         prev_st <= start_o;
      end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   function automatic void exp_stream(input logic [4:0] m, output logic [31:0] b, output int l);
      b = '0;
      l = 0;
      for (int s = 0; s < 5; s++)
         if (m[s])
            for (int i = 0; i < s + 2; i++) begin
               b = {b[30:0], PAT[s][i]};
               l++;
            end
   endfunction

   task automatic accept(input logic [4:0] tc, input logic [1:0] t1v, input logic [3:0] tzv);
      int w = 0;
      while (!blk_ready && w < 100) begin
         tick();
         w++;
      end
      cap_clr = 1'b1;
      total_coeff = tc;
      t1 = t1v;
      total_zeros = tzv;
      blk_valid = 1'b1;
      tick();
      cap_clr = 1'b0;
      blk_valid = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 1;
      while (!blk_done && n < 300) begin
         tick();
         n++;
      end
   endtask

   typedef struct {
      logic [4:0] tc;
      logic [1:0] t1;
      logic [3:0] tz;
      logic [4:0] mask;
      int         cyc;
   } vec_t;
   vec_t tv [7];

   task automatic check_block(input int k);
      int n, el;
      logic [31:0] eb;
      accept(tv[k].tc, tv[k].t1, tv[k].tz);
      wait_done(n);
      exp_stream(tv[k].mask, eb, el);
      chk($sformatf("v%0d cycles", k), n, tv[k].cyc);
      chk($sformatf("v%0d mask", k), got_mask, tv[k].mask);
      chk($sformatf("v%0d order", k), got_order_ok, 1);
      chk($sformatf("v%0d stream", k), got_bits, eb);
      chk($sformatf("v%0d len", k), got_len, el);
      chk($sformatf("v%0d err", k), err_timeout, 0);
      tick();
      chk($sformatf("v%0d done_pulse", k), blk_done, 0);
      chk($sformatf("v%0d ready", k), blk_ready, 1);
   endtask

   initial begin
      int n, w, el, bad;
      logic [31:0] eb;
      // accept cycle + per stage (WAIT + (s+2) RUN + GAP), blk_done on the cycle after
      tv[0] = '{5'd0,  2'd0, 4'd0, 5'b00001, 5};
      tv[1] = '{5'd5,  2'd2, 4'd3, 5'b11111, 31};
      tv[2] = '{5'd16, 2'd3, 4'd0, 5'b00111, 16};
      tv[3] = '{5'd1,  2'd1, 4'd5, 5'b01011, 17};
      tv[4] = '{5'd3,  2'd0, 4'd0, 5'b01101, 18};
      tv[5] = '{5'd2,  2'd0, 4'd2, 5'b11101, 26};
      tv[6] = '{5'd15, 2'd0, 4'd1, 5'b11101, 26};

      tick();
      chk("rst ready", blk_ready, 1);
      chk("rst start", start_o, 0);
      chk("rst push", fifo_push, 0);
      chk("rst data", fifo_data, 0);
      chk("rst done", blk_done, 0);
      chk("rst err", err_timeout, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      for (int k = 0; k < 7; k++) check_block(k);

      // fifo_afull holds WAIT_ROOM before lvl, but never pauses a running stage
      accept(5'd5, 2'd2, 4'd3);
      w = 0;
      while (!finish_i[1] && w < 100) begin
         tick();
         w++;
      end
      fifo_afull = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (start_o != 0) bad++;
      end
      chk("afull held starts", bad, 0);
      fifo_afull = 1'b0;
      tick();
      chk("afull lvl start", start_o, 5'b00100);
      fifo_afull = 1'b1;
      tick();
      chk("afull no pause", start_o, 5'b00100);
      fifo_afull = 1'b0;
      wait_done(n);
      chk("afull done", blk_done, 1);
      exp_stream(5'b11111, eb, el);
      chk("afull stream", got_bits, eb);
      chk("afull len", got_len, el);
      tick();

      // watchdog on a stalled total_zeros stage
      block_fin = 5'b01000;
      accept(5'd5, 2'd2, 4'd3);
      w = 0;
      while (!start_o[3] && w < 100) begin
         tick();
         w++;
      end
      n = 1;
      while (start_o[3] && n < 200) begin
         tick();
         if (start_o[3]) n++;
      end
      chk("wdog run cycles", n, 64);
      chk("wdog err", err_timeout, 1);
      chk("wdog done", blk_done, 1);
      tick();
      chk("wdog ready", blk_ready, 1);
      chk("wdog done_pulse", blk_done, 0);
      chk("wdog err sticky", err_timeout, 1);
      block_fin = '0;

      // asynchronous reset during lvl, then a normal block
      accept(5'd5, 2'd2, 4'd3);
      chk("err cleared on accept", err_timeout, 0);
      w = 0;
      while (!start_o[2] && w < 100) begin
         tick();
         w++;
      end
      chk("pre-rst lvl run", start_o, 5'b00100);
      tick();
      #1 rst = 1'b0;
      #1;
      chk("async rst start", start_o, 0);
      chk("async rst ready", blk_ready, 1);
      chk("async rst push", fifo_push, 0);
      chk("async rst data", fifo_data, 0);
      chk("async rst done", blk_done, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      check_block(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
